// File: rtl/debug_stream_pkg.sv
// Shared types and constants for the debug snapshot byte streamer.
// Frame layout: header, sequence, PC, instruction, then one 4-byte word per register.
package debug_stream_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_SEQ,
      ST_PC,
      ST_INSTR,
      ST_REGS
   } streamState_t;

   localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;
   localparam int         BYTES_PER_WORD      = 4;

   // Header and sequence bytes, then PC, instruction and every register as 32-bit words.
   function automatic int frameLength(input int registerCount);
      return 2 + BYTES_PER_WORD * (registerCount + 2);
   endfunction

endpackage

// File: rtl/word_byte_selector.sv
// Combinational MSB-first byte picker: index 0 returns word[31:24], index 3 returns word[7:0].
module word_byte_selector (
   input  logic [31:0] word,
   input  logic [1:0]  byteIndex,
   output logic [7:0]  byteOut
);

   always_comb begin
      case (byteIndex)
         2'd0:    byteOut = word[31:24];
         2'd1:    byteOut = word[23:16];
         2'd2:    byteOut = word[15:8];
         default: byteOut = word[7:0];
      endcase
   end

endmodule

// File: rtl/debug_snapshot_streamer.sv
// Freezes the CPU debug state on a trigger and streams it out as a byte frame.
// Stream handshake: a byte moves on any rising edge where out_valid && out_ready; once raised, out_valid/out_data/out_last hold until then.
module debug_snapshot_streamer
   import debug_stream_pkg::*;
#(
   parameter logic [7:0] HEADER_BYTE    = DEFAULT_HEADER_BYTE,
   parameter int         REGISTER_COUNT = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [31:0]                  debug_pc,
   input  logic [31:0]                  debug_instruction,
   input  logic [32*REGISTER_COUNT-1:0] debug_registers,
   input  logic                         trigger,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [7:0]                   out_data,
   output logic                         out_last,
   output logic                         busy
);

   localparam int                     REG_IDX_W = (REGISTER_COUNT > 1) ? $clog2(REGISTER_COUNT) : 1;
   localparam logic [REG_IDX_W-1:0]   LAST_REG  = REG_IDX_W'(REGISTER_COUNT - 1);
   localparam logic [1:0]             LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   streamState_t          state, stateNext;
   logic [1:0]            byteIdx;
   logic [REG_IDX_W-1:0]  regIdx;
   logic [7:0]            seqCount;
   logic [31:0]           snapPc;
   logic [31:0]           snapInstr;
   logic [31:0]           snapRegs [REGISTER_COUNT];
   logic [31:0]           currentWord;
   logic [7:0]            wordByte;
   logic                  handshake;
   logic                  wordDone;
   logic                  frameDone;
   logic                  startFrame;
   logic                  inWordState;

   assign handshake   = out_valid && out_ready;
   assign wordDone    = handshake && (byteIdx == LAST_BYTE);
   assign frameDone   = wordDone && (state == ST_REGS) && (regIdx == LAST_REG);
   assign startFrame  = (state == ST_IDLE) && trigger;
   assign inWordState = (state == ST_PC) || (state == ST_INSTR) || (state == ST_REGS);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= stateNext;
   end

   // All outputs decode from registered state, so the async reset clears them at once.
   always_comb begin
      stateNext = state;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_last  = 1'b0;
      out_data  = 8'h00;
      case (state)
         ST_IDLE:   if (trigger)   stateNext = ST_HEADER;
         ST_HEADER: if (handshake) stateNext = ST_SEQ;
         ST_SEQ:    if (handshake) stateNext = ST_PC;
         ST_PC:     if (wordDone)  stateNext = ST_INSTR;
         ST_INSTR:  if (wordDone)  stateNext = ST_REGS;
         ST_REGS:   if (frameDone) stateNext = ST_IDLE;
         default:                  stateNext = ST_IDLE;
      endcase
      if (state != ST_IDLE) begin
         out_valid = 1'b1;
         busy      = 1'b1;
      end
      case (state)
         ST_HEADER:                out_data = HEADER_BYTE;
         ST_SEQ:                   out_data = seqCount;
         ST_PC, ST_INSTR, ST_REGS: out_data = wordByte;
         default:                  out_data = 8'h00;
      endcase
      out_last = (state == ST_REGS) && (byteIdx == LAST_BYTE) && (regIdx == LAST_REG);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         byteIdx  <= 2'd0;
         regIdx   <= '0;
         seqCount <= 8'd0;
      end else begin
         if (handshake && inWordState) byteIdx <= byteIdx + 2'd1;
         if (wordDone && (state == ST_REGS))
            regIdx <= frameDone ? '0 : regIdx + REG_IDX_W'(1);
         if (frameDone) seqCount <= seqCount + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         snapPc    <= 32'd0;
         snapInstr <= 32'd0;
         for (int i = 0; i < REGISTER_COUNT; i++) snapRegs[i] <= 32'd0;
      end else if (startFrame) begin
         snapPc    <= debug_pc;
         snapInstr <= debug_instruction;
         for (int i = 0; i < REGISTER_COUNT; i++) snapRegs[i] <= debug_registers[32*i +: 32];
      end
   end

   always_comb begin
      case (state)
         ST_PC:    currentWord = snapPc;
         ST_INSTR: currentWord = snapInstr;
         default:  currentWord = snapRegs[regIdx];
      endcase
   end

   word_byte_selector byteSel (
      .word      (currentWord),
      .byteIndex (byteIdx),
      .byteOut   (wordByte)
   );

endmodule

// File: tb/tb_debug_snapshot_streamer.sv
// Directed bench for debug_snapshot_streamer: idle, full frames, stalls, mid-frame trigger, reset abort, sequence wrap.
module tb_debug_snapshot_streamer;
   import debug_stream_pkg::*;

   localparam int REGS  = 32;
   localparam int FRAME = frameLength(REGS);

   logic                 clock = 1'b0;
   logic                 reset = 1'b0;
   logic [31:0]          debug_pc = 32'd0;
   logic [31:0]          debug_instruction = 32'd0;
   logic [32*REGS-1:0]   debug_registers = '0;
   logic                 trigger = 1'b0;
   logic                 out_ready = 1'b0;
   logic                 out_valid;
   logic [7:0]           out_data;
   logic                 out_last;
   logic                 busy;

   int compared = 0;
   int mismatched = 0;
   logic [7:0] exp_q[$];

   always #5 clock = ~clock;

   debug_snapshot_streamer #(
      .HEADER_BYTE    (8'hA5),
      .REGISTER_COUNT (REGS)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .debug_pc          (debug_pc),
      .debug_instruction (debug_instruction),
      .debug_registers   (debug_registers),
      .trigger           (trigger),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_last          (out_last),
      .busy              (busy)
   );

   task automatic set_inputs(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] base);
      debug_pc = pc;
      debug_instruction = ins;
      for (int i = 0; i < REGS; i++) debug_registers[32*i +: 32] = base + 32'(i);
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((w >> (24 - 8*k)) & 32'hFF));
   endtask

   task automatic push_frame(input logic [7:0] seq, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] base);
      exp_q.push_back(8'hA5);
      exp_q.push_back(seq);
      push_word(pc);
      push_word(ins);
      for (int i = 0; i < REGS; i++) push_word(base + 32'(i));
   endtask

   task automatic check_quiet(input string name);
      compared++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin
         mismatched++;
         $display("FAIL %s: valid=%b busy=%b last=%b data=%h, required all 0", name, out_valid, busy,
                  out_last, out_data);
      end
   endtask

   task automatic start_frame();
      @(negedge clock);
      trigger = 1'b1;
      @(negedge clock);
      trigger = 1'b0;
      compared++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL trigger_latency: valid=%b busy=%b, required 1 1", out_valid, busy);
      end
   endtask

   // Called at the negedge where the frame's first byte is visible.
   task automatic drain(input bit randomReady, input int pokeAt, input int stopAfter, input int budget,
                        output int cycles);
      int got;
      bit stalled;
      logic [7:0] held;
      logic [7:0] expByte;
      logic expLast;
      got = 0;
      stalled = 1'b0;
      held = 8'h00;
      cycles = 0;
      while (got < stopAfter && cycles < budget) begin
         if (pokeAt >= 0) begin
            trigger = (cycles == pokeAt);
            if (cycles == pokeAt) set_inputs(32'hDEADBEEF, 32'h00000013, 32'h77000000);
         end
         out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         compared++;
         if (out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL valid_held: byte %0d valid=%b, required 1", got, out_valid);
            break;
         end
         if (stalled) begin
            compared++;
            if (out_data !== held) begin
               mismatched++;
               $display("FAIL stall_stable: byte %0d data=%h, required %h", got, out_data, held);
            end
         end
         if (out_ready) begin
            expByte = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            expLast = (got == FRAME - 1);
            compared++;
            if (out_data !== expByte) begin
               mismatched++;
               $display("FAIL frame_byte: byte %0d data=%h, required %h", got, out_data, expByte);
            end
            compared++;
            if (out_last !== expLast) begin
               mismatched++;
               $display("FAIL out_last: byte %0d last=%b, required %b", got, out_last, expLast);
            end
            got++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held = out_data;
         end
         cycles++;
         @(negedge clock);
      end
      compared++;
      if (got < stopAfter) begin
         mismatched++;
         $display("FAIL drain_bound: got %0d bytes, required %0d", got, stopAfter);
      end
   endtask

   task automatic test_reset();
      #1;
      check_quiet("reset_outputs");
      @(negedge clock);
      reset = 1'b1;
      check_quiet("after_release");
   endtask

   task automatic test_idle();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         check_quiet("idle_quiet");
      end
   endtask

   task automatic test_full_frame();
      int cycles;
      set_inputs(32'h00400010, 32'h8C220004, 32'h10000000);
      push_frame(8'h00, 32'h00400010, 32'h8C220004, 32'h10000000);
      start_frame();
      drain(1'b0, -1, FRAME, 400, cycles);
      compared++;
      if (cycles !== FRAME) begin
         mismatched++;
         $display("FAIL frame_cycles: %0d cycles, required %0d", cycles, FRAME);
      end
      check_quiet("frame_end");
   endtask

   task automatic test_stall();
      int cycles;
      push_frame(8'h01, 32'h00400010, 32'h8C220004, 32'h10000000);
      start_frame();
      drain(1'b1, -1, FRAME, 3000, cycles);
      check_quiet("stall_frame_end");
   endtask

   task automatic test_mid_frame_trigger();
      int cycles;
      set_inputs(32'h00400010, 32'h8C220004, 32'h10000000);
      push_frame(8'h02, 32'h00400010, 32'h8C220004, 32'h10000000);
      start_frame();
      drain(1'b0, 40, FRAME, 400, cycles);
      trigger = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_quiet("no_queued_frame");
         @(negedge clock);
      end
   endtask

   task automatic test_reset_mid_frame();
      int cycles;
      set_inputs(32'h00400010, 32'h8C220004, 32'h10000000);
      push_frame(8'h03, 32'h00400010, 32'h8C220004, 32'h10000000);
      start_frame();
      drain(1'b0, -1, 50, 200, cycles);
      reset = 1'b0;
      #1;
      check_quiet("async_reset_clear");
      exp_q.delete();
      @(negedge clock);
      reset = 1'b1;
      set_inputs(32'h12345678, 32'hCAFEF00D, 32'h20000000);
      push_frame(8'h00, 32'h12345678, 32'hCAFEF00D, 32'h20000000);
      start_frame();
      drain(1'b0, -1, FRAME, 400, cycles);
      check_quiet("post_reset_frame_end");
   endtask

   task automatic test_back_to_back();
      int cycles;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      set_inputs(32'h00400010, 32'h8C220004, 32'h10000000);
      trigger = 1'b1;
      @(negedge clock);
      for (int f = 0; f < 257; f++) begin
         push_frame(f[7:0], 32'h00400010, 32'h8C220004, 32'h10000000);
         drain(1'b0, -1, FRAME, 400, cycles);
         check_quiet("idle_gap");
         if (f == 256) trigger = 1'b0;
         @(negedge clock);
      end
      check_quiet("b2b_stop");
   endtask

   initial begin
      test_reset();
      test_idle();
      test_full_frame();
      test_stall();
      test_mid_frame_trigger();
      test_reset_mid_frame();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/debug_snapshot_streamer.md
# debug_snapshot_streamer

Consumes the CPU core's debug outputs (`debug_pc`, `debug_instruction`, `debug_registers`) and, on a trigger, freezes a coherent snapshot and serialises it as a byte stream over a valid/ready interface toward a UART transmitter or host link. It sits directly downstream of the CPU top level in the board wrapper, so architectural state can be inspected without halting the pipeline.

## Interface
Parameters:
- `HEADER_BYTE`, default 8'hA5: first byte of every frame.
- `REGISTER_COUNT`, default 32: registers captured; register i occupies `debug_registers[32*i+31 : 32*i]`.

Ports:
- `clock`  input  1  sole clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `debug_pc`  input  32  CPU program counter.
- `debug_instruction`  input  32  CPU fetched instruction.
- `debug_registers`  input  32*REGISTER_COUNT  flattened register file.
- `trigger`  input  1  request a snapshot; level-sampled each cycle.
- `out_ready`  input  1  sink accepts `out_data` this cycle.
- `out_valid`  output  1  `out_data` holds a valid byte.
- `out_data`  output  8  stream byte.
- `out_last`  output  1  high with the final byte of a frame.
- `busy`  output  1  a frame is being captured or sent.

## Operation
- Frame order: `HEADER_BYTE`, sequence byte, PC (4 bytes), instruction (4 bytes), registers 0..REGISTER_COUNT-1 (4 bytes each). Every word is sent MSB first. Default frame length is 2+8+128 = 138 bytes.
- Sequence byte: 8-bit frame counter, reset 0, incremented after each completed frame, wraps 255→0.
- States: IDLE, HEADER, SEQ, PC, INSTR, REGS.
  - IDLE→HEADER when `trigger`=1.
  - HEADER→SEQ→PC→INSTR→REGS, each on a handshake (`out_valid && out_ready`) of that segment's last byte.
  - REGS→IDLE on the handshake of the last byte of register REGISTER_COUNT-1.
- Counters:
  - 2-bit byte-in-word index selects `word[31-8*k -: 8]`.
  - Register index of width $clog2(REGISTER_COUNT), wraps only via the state change.
- Snapshot: on the IDLE→HEADER edge, PC, instruction and all registers are copied into internal holding registers. Later input changes do not affect the frame in flight.
- `trigger` while not IDLE is ignored; there is no queuing.
- `trigger` held high across the final handshake: the module returns to IDLE for one cycle, then starts a new frame on the next sampled `trigger`.
- `busy` = (state != IDLE).
- `out_last` is asserted only with the final register byte.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0
  - state IDLE, sequence 0, all counters 0, snapshot registers 0.
- Latency: `trigger` sampled at edge N → `out_valid`=1 with the header from edge N (visible in cycle N+1). `busy` rises on the same edge.
- Handshake:
  - Once `out_valid` is asserted, `out_data` and `out_last` stay stable until a handshake.
  - `out_valid` never drops mid-frame without a handshake.
  - After a handshake at edge M, the next byte is presented from edge M. Sustained `out_ready`=1 gives one byte per cycle, so 138 cycles per frame.
- After the last handshake, `out_valid`, `out_last` and `busy` deassert on that same edge.
- Reset asserted mid-frame: all outputs clear immediately (asynchronously) and the sequence counter returns to 0. The partial frame is abandoned, never resumed.
- `out_ready` is ignored while `out_valid`=0.

## Structure
- Shared package `debug_stream_pkg`:
  - state enum
  - `DEFAULT_HEADER_BYTE`
  - `BYTES_PER_WORD`=4
  - frame-length function of REGISTER_COUNT.
- One natural sub-module, `word_byte_selector`: combinational 32→8 MSB-first mux indexed by the byte counter, reused for PC, instruction and register words.
- The snapshot holding registers are 32*(REGISTER_COUNT+2) bits of flops, with no memory macro.

## Test plan
- Reset then idle 20 cycles with `out_ready`=1 → `out_valid`, `busy` and `out_data` remain 0.
- PC=0x00400010, instr=0x8C220004, reg i = 0x1000_0000+i, one `trigger` pulse, `out_ready`=1:
  - 138 bytes in 138 consecutive cycles: A5, 00, 00 40 00 10, 8C 22 00 04, 10 00 00 00, …, 10 00 00 1F.
  - `out_last` only on byte 138.
- Same frame with `out_ready` toggling pseudo-randomly → identical byte sequence, and data is stable during every stall cycle.
- Change all debug inputs and pulse `trigger` again mid-frame → the current frame is unchanged and no second frame follows.
- Send 257 back-to-back frames → the sequence byte reads 00..FF then 00.
- Assert `reset` at byte 50 of a frame → outputs 0 immediately. The next trigger after release emits a full frame with sequence 00.
